// File: rtl/invcdf_share_arb.sv
// invcdf_share_arb: shares one fixed-latency, non-stallable inverse-CDF pipeline
// among N_REQ requesters. Round-robin issue, requester tags ride alongside the
// datapath, and a credit-guarded result FIFO guarantees no result is ever lost.
module invcdf_share_arb #(
  parameter int N_REQ      = 4,
  parameter int WIDTH      = 32,
  parameter int PIPE_LAT   = 7,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = $clog2(N_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*WIDTH-1:0]        req_t,
  input  logic [N_REQ-1:0]              req_neg,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          pipe_valid_in,
  output logic [WIDTH-1:0]              pipe_t,
  output logic                          pipe_negate,
  input  logic                          pipe_valid_out,
  input  logic [WIDTH-1:0]              pipe_z,
  output logic [N_REQ-1:0]              rsp_valid,
  output logic [WIDTH-1:0]              rsp_z,
  input  logic [N_REQ-1:0]              rsp_ready,
  output logic [$clog2(FIFO_DEPTH):0]   outstanding,
  output logic                          tag_err
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic             pipe_valid_in_q, pipe_valid_in_d;
  logic [WIDTH-1:0] pipe_t_q, pipe_t_d;
  logic             pipe_negate_q, pipe_negate_d;
  logic [IDW-1:0]   pipe_id_q, pipe_id_d;

  logic [PIPE_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IDW-1:0]      tag_id_q [PIPE_LAT];
  logic [IDW-1:0]      tag_id_d [PIPE_LAT];

  logic [IDW-1:0]   mem_id_q [FIFO_DEPTH];
  logic [IDW-1:0]   mem_id_d [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_z_q  [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_z_d  [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [CW-1:0]    outstanding_q, outstanding_d;
  logic             tag_err_q, tag_err_d;

  logic             credit, grant_found, accept;
  logic [IDW-1:0]   grant_id, idx;
  logic             tail_vld;
  logic [IDW-1:0]   tail_id, head_id;
  logic             fifo_empty, fifo_full, pop, wr_en;

  // Round-robin search from rr_ptr, gated by credit (and held off during reset)
  always_comb begin
    credit      = (outstanding_q < CW'(FIFO_DEPTH)) && rst_n;
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = IDW'((int'(rr_ptr_q) + off) % N_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
    req_ready = '0;
    accept    = credit && grant_found;
    if (accept) req_ready[grant_id] = 1'b1;
    rr_ptr_d = rr_ptr_q;
    if (accept) rr_ptr_d = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + IDW'(1);
  end

  // Issue registers: one-cycle valid pulse, operand and tag held when idle
  always_comb begin
    pipe_valid_in_d = accept;
    pipe_t_d        = pipe_t_q;
    pipe_negate_d   = pipe_negate_q;
    pipe_id_d       = pipe_id_q;
    if (accept) begin
      pipe_t_d      = req_t[int'(grant_id)*WIDTH +: WIDTH];
      pipe_negate_d = req_neg[grant_id];
      pipe_id_d     = grant_id;
    end
  end

  // Tag shift register fed by the issue strobe so its tail meets pipe_valid_out
  always_comb begin
    tag_vld_d[0] = pipe_valid_in_q;
    tag_id_d[0]  = pipe_id_q;
    for (int i = 1; i < PIPE_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    tail_vld = tag_vld_q[PIPE_LAT-1];
    tail_id  = tag_id_q[PIPE_LAT-1];
  end

  // Result FIFO: written by the tag tail, popped only by the owning requester
  always_comb begin
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CW'(FIFO_DEPTH));
    head_id    = mem_id_q[rd_ptr_q];
    pop        = !fifo_empty && rsp_ready[head_id];
    wr_en      = tail_vld && !fifo_full;
    mem_id_d   = mem_id_q;
    mem_z_d    = mem_z_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (wr_en) begin
      mem_id_d[wr_ptr_q] = tail_id;
      mem_z_d[wr_ptr_q]  = pipe_z;
      wr_ptr_d           = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    rsp_valid = '0;
    if (!fifo_empty) rsp_valid[head_id] = 1'b1;
    rsp_z = mem_z_q[rd_ptr_q];
  end

  // Credit accounting and sticky tag-consistency error
  always_comb begin
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    tag_err_d = tag_err_q | (pipe_valid_out != tail_vld) | (tail_vld & fifo_full);
  end

  // Arbiter, issue and status state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q        <= '0;
      pipe_valid_in_q <= 1'b0;
      pipe_t_q        <= '0;
      pipe_negate_q   <= 1'b0;
      pipe_id_q       <= '0;
      outstanding_q   <= '0;
      tag_err_q       <= 1'b0;
    end else begin
      rr_ptr_q        <= rr_ptr_d;
      pipe_valid_in_q <= pipe_valid_in_d;
      pipe_t_q        <= pipe_t_d;
      pipe_negate_q   <= pipe_negate_d;
      pipe_id_q       <= pipe_id_d;
      outstanding_q   <= outstanding_d;
      tag_err_q       <= tag_err_d;
    end
  end

  // Tag pipeline and FIFO storage; reset discards everything in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q <= '0;
      for (int i = 0; i < PIPE_LAT; i++) tag_id_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_id_q[i] <= '0;
        mem_z_q[i]  <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      mem_id_q  <= mem_id_d;
      mem_z_q   <= mem_z_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign pipe_valid_in = pipe_valid_in_q;
  assign pipe_t        = pipe_t_q;
  assign pipe_negate   = pipe_negate_q;
  assign outstanding   = outstanding_q;
  assign tag_err       = tag_err_q;

endmodule

// File: doc/invcdf_share_arb.md
Name: invcdf_share_arb

Overview:
- Shares one fixed-latency, non-stallable inverse-CDF pipeline (t/negate in, signed Q16.16 z-score out) among N_REQ requesters, e.g. parallel QMC path generators.
- Round-robin arbitration, requester-ID tag tracking through the pipeline, and a credit-guarded result FIFO. Results can never be dropped, even though the pipeline has no backpressure.
- Sits between the sampler lanes and the single inverse-CDF instance.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- WIDTH, 32, data width of t and z (Q16.16).
- PIPE_LAT, 7, cycles from pipe_valid_in to pipe_valid_out of the shared datapath.
- FIFO_DEPTH, 8, result FIFO entries; also the maximum number of outstanding operations. Power of two, at least 2.
- IDW, $clog2(N_REQ), requester tag width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester request valid
- req_t  in  N_REQ*WIDTH  packed t operands; requester i uses bits [i*WIDTH +: WIDTH]
- req_neg  in  N_REQ  per-requester negate flag
- req_ready  out  N_REQ  one-hot (or zero) grant/accept
- pipe_valid_in  out  1  issue strobe to the datapath
- pipe_t  out  WIDTH  operand to the datapath
- pipe_negate  out  1  negate to the datapath
- pipe_valid_out  in  1  datapath result strobe
- pipe_z  in  WIDTH  datapath result (signed)
- rsp_valid  out  N_REQ  one-hot result valid for the owning requester
- rsp_z  out  WIDTH  result data, shared by all requesters
- rsp_ready  in  N_REQ  per-requester result accept
- outstanding  out  $clog2(FIFO_DEPTH)+1  issued operations not yet popped
- tag_err  out  1  sticky: result strobe and tag pipeline disagree

Behaviour:
- Reset (async) clears the following to 0:
  - pipe_valid_in, pipe_t, pipe_negate
  - req_ready, rsp_valid, rsp_z
  - outstanding, tag_err
  - tag pipeline, FIFO pointers
  - round-robin pointer (points at requester 0)
- Reset mid-operation discards all in-flight and buffered results. Any datapath output arriving after reset is ignored because no tag is valid.
- Credit rule: an issue is allowed only when outstanding < FIFO_DEPTH. A same-cycle pop does not allow an extra issue.
- Arbitration:
  - Combinational.
  - When credit is available, req_ready goes to the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - At most one bit of req_ready is set. req_ready is 0 for every requester when there is no credit.
  - Acceptance is req_valid[i] & req_ready[i].
  - On acceptance, rr_ptr becomes (i+1) mod N_REQ. Without acceptance, rr_ptr holds.
- Issue:
  - Acceptance at edge k registers pipe_valid_in=1, pipe_t=req_t[i] and pipe_negate=req_neg[i], visible in cycle k+1.
  - pipe_valid_in is a 1-cycle pulse per acceptance; back-to-back issue every cycle is allowed.
  - pipe_t and pipe_negate hold their last value when idle.
- Tag pipeline:
  - PIPE_LAT-stage shift register of {valid, id}, loaded in lockstep with pipe_valid_in.
  - The tail lines up with pipe_valid_out.
  - If pipe_valid_out differs from the tail valid bit, tag_err is set and stays set until reset.
  - The FIFO write is gated by the tail valid bit only.
- Result FIFO:
  - {id, pipe_z} is written when the tail valid bit is set.
  - Overflow is impossible by the credit rule. Any write into a full FIFO also sets tag_err.
- Response:
  - When the FIFO is non-empty, rsp_valid[head.id]=1 and rsp_z=head.z, both registered/held stable until popped.
  - Pop occurs when rsp_ready[head.id]=1. rsp_ready bits of other requesters are ignored.
  - Results are delivered in strict issue order, so head-of-line blocking is accepted.
- outstanding: +1 on acceptance, −1 on pop, unchanged when both happen in the same cycle.
- Minimum latency: acceptance at edge k gives pipe_valid_out in cycle k+1+PIPE_LAT and rsp_valid in cycle k+2+PIPE_LAT.
- The FIFO can be written and popped in the same cycle when it is non-empty. Pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Single request: requester 2 sends t=0x0002_0000, neg=1, with an ideal delay-line datapath model (z = t xor 0xFFFF) and rsp_ready all 1 → pipe_valid_in in cycle k+1; rsp_valid=4'b0100 and rsp_z=0x0002_FFFF in cycle k+9; outstanding returns to 0.
- All four requesters valid continuously, rsp_ready=1 → grants cycle 0,1,2,3,0,… one per cycle; 100 results arrive in order with matching ids; tag_err stays 0.
- rsp_ready held at 0 with requester 0 streaming → exactly 8 acceptances, then req_ready=0 and outstanding=8; releasing rsp_ready drains all 8 and issue resumes.
- Head-of-line: results queued for ids 1 then 3, rsp_ready=4'b1000 only → no pop; rsp_valid stays 4'b0010 with stable data until rsp_ready[1]=1.
- Spurious pipe_valid_out injected with no tag valid → tag_err=1 (sticky); no FIFO write; outstanding unchanged.
- rst_n asserted with 5 results in flight → all outputs 0 immediately; in-flight results arriving after release are not delivered; grants start again from requester 0.
